cla_adder_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready flow control, the general-width successor to the fixed 24-bit CLA used in the FPU mantissa path. The operand width is split into equal segments, and one segment is resolved per pipeline stage with 4-bit CLA groups and a group-level lookahead carry. The carry is registered between stages. The block sits between the FPU alignment shifter and the normaliser, and supports full-rate streaming with backpressure.

---
 rtl/cla_adder_pipe_if.sv | 26 ++
 rtl/cla_adder_pipe.sv | 141 ++++++++++++++
 tb/tb_cla_adder_pipe.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cla_adder_pipe_if.sv
// Operand/result bus of cla_adder_pipe: valid/ready on both the operand and the result side.
interface cla_adder_pipe_if #(
   parameter int WIDTH = 24
);
   logic             i_valid;
   logic             o_ready;
   logic             i_sub;
   logic             i_carry;
   logic [WIDTH-1:0] i_data_a;
   logic [WIDTH-1:0] i_data_b;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_sum;
   logic             o_carry;
   logic             o_overflow;

   modport slave (
      input  i_valid, i_sub, i_carry, i_data_a, i_data_b, i_ready,
      output o_ready, o_valid, o_sum, o_carry, o_overflow
   );

   modport master (
      output i_valid, i_sub, i_carry, i_data_a, i_data_b, i_ready,
      input  o_ready, o_valid, o_sum, o_carry, o_overflow
   );
endinterface

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one SEG_W-bit segment per stage, built from
// 4-bit CLA groups joined by a group-level lookahead, with a single global advance enable.
module cla_adder_pipe #(
   parameter int WIDTH      = 24,
   parameter int NUM_STAGES = 2
) (
   input logic             i_clk,
   input logic             i_rst,
   cla_adder_pipe_if.slave bus
);
   localparam int SEG_W   = WIDTH / NUM_STAGES;
   localparam int NUM_GRP = SEG_W / 4;

   logic             w_adv;
   logic             r_outValid;
   logic             r_outCarry;
   logic             r_outOvf;
   logic [WIDTH-1:0] r_outSum;

   // Returns {carry-out, sum}; every carry is a sum of products back to cin, never a ripple.
   function automatic logic [SEG_W:0] claSegment(input logic [SEG_W-1:0] a,
                                                 input logic [SEG_W-1:0] b,
                                                 input logic             cin);
      logic [SEG_W-1:0]   p;
      logic [SEG_W-1:0]   g;
      logic [SEG_W-1:0]   s;
      logic [NUM_GRP-1:0] grpP;
      logic [NUM_GRP-1:0] grpG;
      logic [NUM_GRP:0]   grpC;
      logic               carry;
      logic               prod;
      p = a ^ b;
      g = a & b;
      s = '0;
      for (int k = 0; k < NUM_GRP; k++) begin
         grpP[k] = &p[4*k +: 4];
         grpG[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                 | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      end
      grpC[0] = cin;
      for (int k = 0; k < NUM_GRP; k++) begin
         carry = 1'b0;
         prod  = 1'b1;
         for (int j = k; j >= 0; j--) begin
            carry = carry | (prod & grpG[j]);
            prod  = prod & grpP[j];
         end
         grpC[k+1] = carry | (prod & cin);
      end
      for (int k = 0; k < NUM_GRP; k++) begin
         for (int i = 0; i < 4; i++) begin
            carry = 1'b0;
            prod  = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
               carry = carry | (prod & g[4*k+j]);
               prod  = prod & p[4*k+j];
            end
            s[4*k+i] = p[4*k+i] ^ (carry | (prod & grpC[k]));
         end
      end
      return {grpC[NUM_GRP], s};
   endfunction

   assign w_adv          = ~r_outValid | bus.i_ready;
   assign bus.o_ready    = w_adv;
   assign bus.o_valid    = r_outValid;
   assign bus.o_sum      = r_outSum;
   assign bus.o_carry    = r_outCarry;
   assign bus.o_overflow = r_outOvf;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : gStage
      localparam int REM_W = WIDTH - k * SEG_W;

      logic [REM_W-1:0]         w_aRem;
      logic [REM_W-1:0]         w_bRem;
      logic                     w_cin;
      logic                     w_valid;
      logic [SEG_W:0]           w_seg;
      logic [(k+1)*SEG_W-1:0]   w_sumDone;

      assign w_seg = claSegment(w_aRem[SEG_W-1:0], w_bRem[SEG_W-1:0], w_cin);

      if (k == 0) begin : gIn
         assign w_aRem    = bus.i_data_a;
         assign w_bRem    = bus.i_sub ? ~bus.i_data_b : bus.i_data_b;
         assign w_cin     = bus.i_sub | bus.i_carry;
         assign w_valid   = bus.i_valid;
         assign w_sumDone = w_seg[SEG_W-1:0];
      end else begin : gMid
         assign w_aRem    = gStage[k-1].gFwd.r_aRem;
         assign w_bRem    = gStage[k-1].gFwd.r_bRem;
         assign w_cin     = gStage[k-1].gFwd.r_carry;
         assign w_valid   = gStage[k-1].gFwd.r_valid;
         assign w_sumDone = {w_seg[SEG_W-1:0], gStage[k-1].gFwd.r_sumDone};
      end

      if (k < NUM_STAGES - 1) begin : gFwd
         logic                     r_valid;
         logic                     r_carry;
         logic [REM_W-SEG_W-1:0]   r_aRem;
         logic [REM_W-SEG_W-1:0]   r_bRem;
         logic [(k+1)*SEG_W-1:0]   r_sumDone;

         // Upper operand bits travel on untouched; finished low sum bits are carried forward.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_valid   <= 1'b0;
               r_carry   <= 1'b0;
               r_aRem    <= '0;
               r_bRem    <= '0;
               r_sumDone <= '0;
            end else if (w_adv) begin
               r_valid   <= w_valid;
               r_carry   <= w_seg[SEG_W];
               r_aRem    <= w_aRem[REM_W-1:SEG_W];
               r_bRem    <= w_bRem[REM_W-1:SEG_W];
               r_sumDone <= w_sumDone;
            end
         end
      end else begin : gOut
         logic w_ovf;

         assign w_ovf = (w_aRem[REM_W-1] == w_bRem[REM_W-1]) &&
                        (w_sumDone[WIDTH-1] != w_aRem[REM_W-1]);

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_outValid <= 1'b0;
               r_outCarry <= 1'b0;
               r_outOvf   <= 1'b0;
               r_outSum   <= '0;
            end else if (w_adv) begin
               r_outValid <= w_valid;
               r_outCarry <= w_seg[SEG_W];
               r_outOvf   <= w_ovf;
               r_outSum   <= w_sumDone;
            end
         end
      end
   end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed bench for cla_adder_pipe at WIDTH=24, NUM_STAGES=2 with hand-computed results.
module tb_cla_adder_pipe;
   localparam int WIDTH = 24;
   localparam int NS    = 2;

   logic clk = 1'b0;
   logic rst;
   int   compareCount = 0;
   int   failCount    = 0;

   always #5 clk = ~clk;

   cla_adder_pipe_if #(.WIDTH(WIDTH)) bus ();

   cla_adder_pipe #(.WIDTH(WIDTH), .NUM_STAGES(NS)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Backpressure stream: operands, mode and the expected {sum, carry, overflow}.
   logic [23:0] bpA   [8] = '{24'h000001, 24'h0000FF, 24'hFFF000, 24'h400000,
                              24'h000010, 24'h000000, 24'hABCDEF, 24'h7FFFFF};
   logic [23:0] bpB   [8] = '{24'h000002, 24'h000F01, 24'h001000, 24'h400000,
                              24'h000001, 24'h000001, 24'h000000, 24'hFFFFFF};
   logic        bpSub [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic        bpCin [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [23:0] bpSum [8] = '{24'h000003, 24'h001000, 24'h000000, 24'h800000,
                              24'h00000F, 24'hFFFFFF, 24'hABCDF0, 24'h800000};
   logic        bpCo  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic        bpOv  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic        readyPat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b,
                                input logic sub, input logic cin);
      bus.i_valid  = 1'b1;
      bus.i_data_a = a;
      bus.i_data_b = b;
      bus.i_sub    = sub;
      bus.i_carry  = cin;
   endtask

   // Starts at a negedge with an empty pipe and i_ready high; checks two-edge latency.
   task automatic runOne(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input logic sub, input logic cin, input logic [31:0] expSum,
                         input logic [31:0] expCo, input logic [31:0] expOv);
      applyStimulus(a, b, sub, cin);
      @(posedge clk);
      #1 bus.i_valid = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_validEarly"}, 32'(bus.o_valid), 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_valid"}, 32'(bus.o_valid), 1);
      checkOutput({tag, "_sum"}, 32'(bus.o_sum), expSum);
      checkOutput({tag, "_carry"}, 32'(bus.o_carry), expCo);
      checkOutput({tag, "_ovf"}, 32'(bus.o_overflow), expOv);
   endtask

   initial begin
      int  sendIdx;
      int  recvIdx;
      logic model0;
      logic modelOut;
      logic adv;
      logic acc;
      logic consumed;

      rst = 1'b1;
      bus.i_ready = 1'b1;
      applyStimulus(24'h0, 24'h0, 1'b0, 1'b0);
      bus.i_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_valid", 32'(bus.o_valid), 0);
      checkOutput("reset_sum", 32'(bus.o_sum), 0);
      checkOutput("reset_carry", 32'(bus.o_carry), 0);
      checkOutput("reset_ovf", 32'(bus.o_overflow), 0);
      checkOutput("reset_ready", 32'(bus.o_ready), 1);

      $display("[TB] directed vectors");
      runOne("addBasic", 24'h00FFFF, 24'h000001, 1'b0, 1'b0, 'h010000, 0, 0);
      runOne("addChain", 24'hFFFFFF, 24'h000000, 1'b0, 1'b1, 'h000000, 1, 0);
      runOne("addOvf",   24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 'h800000, 0, 1);
      runOne("subBorrow",24'h000005, 24'h000007, 1'b1, 1'b0, 'hFFFFFE, 0, 0);
      runOne("subOvf",   24'h800000, 24'h000001, 1'b1, 1'b0, 'h7FFFFF, 1, 1);
      runOne("subCinIgn",24'h000010, 24'h000010, 1'b1, 1'b1, 'h000000, 1, 0);
      runOne("addMixed", 24'h123456, 24'h654321, 1'b0, 1'b1, 'h777778, 0, 0);
      runOne("addNegOvf",24'h800000, 24'h800000, 1'b0, 1'b0, 'h000000, 1, 1);

      @(posedge clk);
      @(negedge clk);
      checkOutput("drain_valid", 32'(bus.o_valid), 0);

      $display("[TB] backpressure stream");
      sendIdx  = 0;
      recvIdx  = 0;
      model0   = 1'b0;
      modelOut = 1'b0;
      for (int c = 0; c < 40 && recvIdx < 8; c++) begin
         bus.i_ready = (c < 8) ? readyPat[c] : 1'b1;
         if (sendIdx < 8)
            applyStimulus(bpA[sendIdx], bpB[sendIdx], bpSub[sendIdx], bpCin[sendIdx]);
         else
            bus.i_valid = 1'b0;
         #1;
         adv = ~modelOut | bus.i_ready;
         checkOutput("bp_valid", 32'(bus.o_valid), 32'(modelOut));
         checkOutput("bp_ready", 32'(bus.o_ready), 32'(adv));
         if (modelOut && recvIdx < 8) begin
            checkOutput("bp_sum", 32'(bus.o_sum), 32'(bpSum[recvIdx]));
            checkOutput("bp_carry", 32'(bus.o_carry), 32'(bpCo[recvIdx]));
            checkOutput("bp_ovf", 32'(bus.o_overflow), 32'(bpOv[recvIdx]));
         end
         acc      = adv && (sendIdx < 8);
         consumed = modelOut && bus.i_ready;
         @(posedge clk);
         if (adv) begin
            modelOut = model0;
            model0   = acc;
         end
         if (acc) sendIdx++;
         if (consumed) recvIdx++;
         @(negedge clk);
      end
      checkOutput("bp_received", 32'(recvIdx), 8);
      checkOutput("bp_noExtra", 32'(bus.o_valid), 0);

      $display("[TB] reset mid-flight");
      bus.i_ready = 1'b1;
      applyStimulus(24'h111111, 24'h222222, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(24'hFFFFFF, 24'h000001, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("preRst_valid", 32'(bus.o_valid), 1);
      checkOutput("preRst_sum", 32'(bus.o_sum), 'h333333);
      rst = 1'b1;
      bus.i_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midRst_valid", 32'(bus.o_valid), 0);
      checkOutput("midRst_sum", 32'(bus.o_sum), 0);
      checkOutput("midRst_carry", 32'(bus.o_carry), 0);
      checkOutput("midRst_ovf", 32'(bus.o_overflow), 0);
      checkOutput("midRst_ready", 32'(bus.o_ready), 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("postRst_noStale", 32'(bus.o_valid), 0);
      end
      runOne("postRst", 24'h0F0F0F, 24'h010101, 1'b0, 1'b0, 'h101010, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end
endmodule
